// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit-entry stage.
package keypad_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACCEPT,
    RELEASE
  } key_state_t;

endpackage

// File: rtl/key_encoder.sv
// 10-to-4 priority encoder for the digit keys: lowest set bit wins,
// o_none flags that no key is pressed.
module key_encoder
  import keypad_pkg::*;
(
  input  logic [9:0]       i_keys,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_none
);

  // Scan from the top down so the lowest pressed index is the last write.
  always_comb begin
    o_digit = '0;
    o_none  = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      if (i_keys[i]) begin
        o_digit = BCD_W'(i);
        o_none  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Microwave front-panel digit entry: debounces the digit keys, shifts
// accepted digits into an MM:SS buffer and strobes loadn on a valid start.
//
// Build option: KEYPAD_ENTRY_SECLIMIT_EN rejects a digit whose shift would
// put a value above 5 into sec_tens.
//
// state    | meaning
// IDLE     | no key held, waiting for a press
// DEBOUNCE | same digit seen for r_count consecutive cycles
// ACCEPT   | one cycle: digit shifted in unless busy/loading/rejected
// RELEASE  | waiting for DEBOUNCE_CYCLES consecutive key-free cycles
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic [9:0]       keys,
  input  logic             start,
  input  logic             clear,
  input  logic             busy,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             loadn,
  output logic             key_strobe,
  output logic             entry_valid
);

  localparam logic [8:0] C_DEB = 9'(DEBOUNCE_CYCLES);

  key_state_t       r_state;
  logic [7:0]       r_count;
  logic [BCD_W-1:0] r_digit;
  logic [BCD_W-1:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic             r_loadn;
  logic             r_key_strobe;

  logic [BCD_W-1:0] w_digit;
  logic             w_none;
  logic [8:0]       w_count_inc;
  logic             w_accept;
  logic             w_sec_ok;
  logic             w_buf_clr;
  logic             w_shift;
  logic             w_fire;

  key_encoder u_encoder (
    .i_keys  (keys),
    .o_digit (w_digit),
    .o_none  (w_none)
  );

  assign w_count_inc = {1'b0, r_count} + 9'd1;
  assign w_accept    = (r_state == ACCEPT);

`ifdef KEYPAD_ENTRY_SECLIMIT_EN
  // sec_ones becomes sec_tens after the shift, so it must already be legal.
  assign w_sec_ok = (r_sec_ones <= SEC_TENS_MAX);
`else
  assign w_sec_ok = 1'b1;
`endif

  // The cycle with loadn low ends by zeroing the buffer; clear beats a shift.
  assign w_buf_clr = clear || !r_loadn;
  assign w_shift   = w_accept && !busy && r_loadn && w_sec_ok && !w_buf_clr;
  assign w_fire    = start && !busy && entry_valid && !w_accept && r_loadn;

  assign entry_valid = (r_sec_tens <= SEC_TENS_MAX) &&
                       ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} != '0);

  assign min_tens   = r_min_tens;
  assign min_ones   = r_min_ones;
  assign sec_tens   = r_sec_tens;
  assign sec_ones   = r_sec_ones;
  assign loadn      = r_loadn;
  assign key_strobe = r_key_strobe;

  // Press/release debounce state machine.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_digit <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_none) begin
            r_digit <= w_digit;
            r_count <= 8'd1;
            r_state <= (C_DEB == 9'd1) ? ACCEPT : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!w_none && (w_digit == r_digit)) begin
            if (w_count_inc == C_DEB) begin
              r_state <= ACCEPT;
              r_count <= '0;
            end else begin
              r_count <= w_count_inc[7:0];
            end
          end else begin
            r_state <= IDLE;
            r_count <= '0;
          end
        end
        ACCEPT: begin
          r_state <= RELEASE;
          r_count <= '0;
        end
        RELEASE: begin
          if (w_none) begin
            if (w_count_inc == C_DEB) begin
              r_state <= IDLE;
              r_count <= '0;
            end else begin
              r_count <= w_count_inc[7:0];
            end
          end else begin
            r_count <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // MM:SS entry buffer: clear/load-complete zeroes it, an accepted key shifts left.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_min_tens <= '0;
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (w_buf_clr) begin
      r_min_tens <= '0;
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (w_shift) begin
      r_min_tens <= r_min_ones;
      r_min_ones <= r_sec_tens;
      r_sec_tens <= r_sec_ones;
      r_sec_ones <= r_digit;
    end
  end

  // Registered one-cycle strobes: loadn on a valid start, key_strobe on a shift.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_loadn      <= 1'b1;
      r_key_strobe <= 1'b0;
    end else begin
      r_loadn      <= !w_fire;
      r_key_strobe <= w_shift;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed vector table, hand-written
// multi-cycle sequences, then randomized stimulus against a reference model.
`timescale 1ns/1ps
module tb_keypad_entry;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       clrn  = 1'b0;
  logic [9:0] keys  = '0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       busy  = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, key_strobe, entry_valid;
  logic [15:0] cur_buf;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock       (clock),
    .clrn        (clrn),
    .keys        (keys),
    .start       (start),
    .clear       (clear),
    .busy        (busy),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .loadn       (loadn),
    .key_strobe  (key_strobe),
    .entry_valid (entry_valid)
  );

  always #5 clock = ~clock;

  assign cur_buf = {min_tens, min_ones, sec_tens, sec_ones};

  always @(negedge clock) if (key_strobe === 1'b1) strobe_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    keys = '0; start = 1'b0; clear = 1'b0; busy = 1'b0;
    repeat (2) @(negedge clock);
    clrn = 1'b1;
    @(negedge clock);
  endtask

  task automatic press(input logic [9:0] m, input int hold);
    keys = m;
    repeat (hold) @(negedge clock);
    keys = '0;
    repeat (6) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  int m_buf[4];
  bit m_loadn, m_strobe, m_acc, m_rel;
  int m_run, m_run_dig, m_rel_len, m_acc_dig;

  function automatic int enc(input logic [9:0] k);
    for (int i = 0; i < 10; i++) if (k[i]) return i;
    return -1;
  endfunction

  function automatic bit m_valid();
    return (m_buf[2] <= 5) && ((m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3]) != 0);
  endfunction

  function automatic void model_reset();
    m_buf = '{0, 0, 0, 0};
    m_loadn = 1; m_strobe = 0; m_acc = 0; m_rel = 0;
    m_run = 0; m_run_dig = 0; m_rel_len = 0; m_acc_dig = 0;
  endfunction

  function automatic void model_step(input logic [9:0] k, input logic st, input logic cl, input logic bz);
    int d;
    bit acc_now, clr_buf, shift, fire, sec_ok;
    d = enc(k);
    acc_now = m_acc;
    sec_ok = 1;
`ifdef KEYPAD_ENTRY_SECLIMIT_EN
    sec_ok = (m_buf[3] <= 5);
`endif
    clr_buf = cl || !m_loadn;
    shift = acc_now && !bz && m_loadn && sec_ok && !clr_buf;
    fire = st && !bz && m_valid() && !acc_now && m_loadn;
    if (clr_buf) m_buf = '{0, 0, 0, 0};
    else if (shift) m_buf = '{m_buf[1], m_buf[2], m_buf[3], m_acc_dig};
    m_strobe = shift;
    m_loadn = !fire;
    // a press is a run of DEB identical digits; then DEB key-free cycles re-arm
    if (acc_now) begin
      m_acc = 0; m_rel = 1; m_rel_len = 0;
    end else if (m_rel) begin
      if (d < 0) begin
        m_rel_len++;
        if (m_rel_len == DEB) begin m_rel = 0; m_run = 0; end
      end else m_rel_len = 0;
    end else begin
      if (m_run == 0) begin
        if (d >= 0) begin m_run_dig = d; m_run = 1; end
      end else if (d == m_run_dig) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin m_acc = 1; m_acc_dig = m_run_dig; m_run = 0; end
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [9:0]  mask;
    int          hold;
    logic        bz;
    logic [15:0] exp_buf;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int base, lows;
    logic [18:0] exp_v;
    logic [9:0] cur_mask;
    int hold_left;

    vecs[0]  = '{10'h002, 6, 1'b0, 16'h0001, 1};
    vecs[1]  = '{10'h004, 6, 1'b0, 16'h0012, 1};
    vecs[2]  = '{10'h008, 6, 1'b0, 16'h0123, 1};
    vecs[3]  = '{10'h001, 6, 1'b0, 16'h1230, 1};
    vecs[4]  = '{10'h002, 6, 1'b0, 16'h2301, 1};
    vecs[5]  = '{10'h004, 6, 1'b0, 16'h3012, 1};
    vecs[6]  = '{10'h008, 6, 1'b0, 16'h0123, 1};
    vecs[7]  = '{10'h010, 6, 1'b0, 16'h1234, 1};
    vecs[8]  = '{10'h020, 6, 1'b0, 16'h2345, 1};
    vecs[9]  = '{10'h080, 6, 1'b1, 16'h2345, 0};
    vecs[10] = '{10'h3F0, 6, 1'b0, 16'h3454, 1};
    vecs[11] = '{10'h200, 3, 1'b0, 16'h3454, 0};
    vecs[12] = '{10'h220, 6, 1'b0, 16'h4545, 1};
    vecs[13] = '{10'h200, 6, 1'b0, 16'h5459, 1};

    // reset state, both during and after reset
    clrn = 1'b0;
    #12;
    check("reset_in", {cur_buf, loadn, key_strobe, entry_valid}, {16'h0, 1'b1, 1'b0, 1'b0});
    do_reset();
    check("reset_out", {cur_buf, loadn, key_strobe, entry_valid}, {16'h0, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 14; i++) begin
      base = strobe_cnt;
      busy = vecs[i].bz;
      press(vecs[i].mask, vecs[i].hold);
      busy = 1'b0;
      check($sformatf("vec%0d_buf", i), cur_buf, vecs[i].exp_buf);
      check($sformatf("vec%0d_strobes", i), strobe_cnt - base, vecs[i].exp_strobes);
    end

    // bounce: 3 cycles, gap, 2 cycles -> nothing accepted
    base = strobe_cnt;
    keys = 10'h020; repeat (3) @(negedge clock);
    keys = '0; @(negedge clock);
    keys = 10'h020; repeat (2) @(negedge clock);
    keys = '0; repeat (6) @(negedge clock);
    check("bounce_buf", cur_buf, 16'h5459);
    check("bounce_strobes", strobe_cnt - base, 0);

    // start with valid 01:30, start held three cycles
    do_reset();
    press(10'h001, 6); press(10'h002, 6); press(10'h008, 6); press(10'h001, 6);
    check("start_pre", {cur_buf, entry_valid}, {16'h0130, 1'b1});
    start = 1'b1;
    @(posedge clock); #1;
    check("start_low", {cur_buf, loadn}, {16'h0130, 1'b0});
    @(posedge clock); #1;
    check("start_after", {cur_buf, loadn, entry_valid}, {16'h0000, 1'b1, 1'b0});
    @(posedge clock); #1;
    check("start_held_norefire", loadn, 1'b1);
    @(negedge clock);
    start = 1'b0;

    // busy blocks start and entry
    press(10'h001, 6); press(10'h002, 6); press(10'h008, 6); press(10'h001, 6);
    busy = 1'b1;
    start = 1'b1;
    lows = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (loadn !== 1'b1) lows++;
    end
    @(negedge clock);
    start = 1'b0;
    check("busy_loadn_lows", lows, 0);
    base = strobe_cnt;
    press(10'h080, 6);
    check("busy_key_buf", cur_buf, 16'h0130);
    check("busy_key_strobes", strobe_cnt - base, 0);
    busy = 1'b0;

    // start coincident with ACCEPT: key wins, held start fires next cycle
    keys = 10'h004;
    repeat (4) @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    check("acc_start_key", {cur_buf, loadn, key_strobe}, {16'h1302, 1'b1, 1'b1});
    @(posedge clock); #1;
    check("acc_start_fire", {cur_buf, loadn}, {16'h1302, 1'b0});
    @(posedge clock); #1;
    check("acc_start_done", {cur_buf, loadn}, {16'h0000, 1'b1});
    @(negedge clock);
    start = 1'b0; keys = '0;
    repeat (6) @(negedge clock);

    // clear wins over a shift in the same cycle
    press(10'h008, 6);
    keys = 10'h010;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    check("clear_vs_shift", {cur_buf, key_strobe}, {16'h0000, 1'b0});
    @(negedge clock);
    clear = 1'b0; keys = '0;
    repeat (6) @(negedge clock);

    // 0,0,7,0 entry
    do_reset();
    base = strobe_cnt;
    press(10'h001, 6); press(10'h001, 6); press(10'h080, 6); press(10'h001, 6);
`ifdef KEYPAD_ENTRY_SECLIMIT_EN
    check("sec7_rejected_buf", cur_buf, 16'h0007);
    check("sec7_rejected_strobes", strobe_cnt - base, 3);
`else
    check("sec7_buf", {cur_buf, entry_valid}, {16'h0070, 1'b0});
    start = 1'b1;
    lows = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (loadn !== 1'b1) lows++;
    end
    @(negedge clock);
    start = 1'b0;
    check("sec7_start_ignored", lows, 0);
`endif

    // clrn during debounce
    do_reset();
    press(10'h004, 6); press(10'h010, 6);
    check("pre_clrn_buf", cur_buf, 16'h0024);
    keys = 10'h040;
    repeat (2) @(negedge clock);
    #2 clrn = 1'b0;
    #1 check("clrn_debounce", {cur_buf, loadn, key_strobe, entry_valid}, {16'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clock);
    clrn = 1'b1; keys = '0;
    repeat (6) @(negedge clock);
    base = strobe_cnt;
    press(10'h100, 6);
    check("post_clrn_press", {cur_buf, 4'(strobe_cnt - base)}, {16'h0008, 4'd1});

    // clrn during loadn-low cycle
    start = 1'b1;
    @(posedge clock); #1;
    check("clrn_load_pre", {cur_buf, loadn}, {16'h0008, 1'b0});
    start = 1'b0;
    #2 clrn = 1'b0;
    #1 check("clrn_loadn", {cur_buf, loadn, key_strobe, entry_valid}, {16'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clock);
    clrn = 1'b1;
    @(negedge clock);
    press(10'h008, 6);
    check("post_clrn_load_press", cur_buf, 16'h0003);

    // randomized stimulus against the reference model
    do_reset();
    model_reset();
    cur_mask = '0;
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 19))
          0, 1, 2, 3, 4, 5, 6, 7: cur_mask = '0;
          17, 18, 19:             cur_mask = 10'($urandom_range(1, 1023));
          default:                cur_mask = 10'(1 << $urandom_range(0, 9));
        endcase
        hold_left = $urandom_range(1, 9);
      end
      hold_left--;
      keys  = cur_mask;
      start = ($urandom_range(0, 9) == 0);
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) busy = ~busy;
      model_step(keys, start, clear, busy);
      exp_v = {4'(m_buf[0]), 4'(m_buf[1]), 4'(m_buf[2]), 4'(m_buf[3]),
               m_loadn, m_strobe, m_valid()};
      @(posedge clock); #1;
      check($sformatf("rand_c%0d", c), {cur_buf, loadn, key_strobe, entry_valid}, exp_v);
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
